// File: rtl/uart_tx.sv
// uart_tx: asynchronous serial transmitter for the debug dump path.
// Frame = start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// The byte is latched on the acceptance edge, and busy/tx are registered so
// the start bit and busy both appear on that same edge.
module uart_tx #(
  parameter int CLKDIV   = 868,  // clock cycles per bit, >= 2
  parameter int PARITY   = 0,    // 0 none, 1 odd, 2 even
  parameter int STOPBITS = 1     // 1 or 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       txen,
  input  logic [7:0] din,
  output logic       busy,
  output logic       tx
);

  localparam int TW = $clog2(CLKDIV);
  localparam logic [TW-1:0] TLOAD = TW'(CLKDIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    idx_q,   idx_d;
  logic          stop_q,  stop_d;   // stop bits already completed
  logic          par_q,   par_d;
  logic          tx_q,    tx_d;
  logic          busy_q,  busy_d;
  logic          tick;

  assign tick = (timer_q == '0);

  // State and datapath registers; reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: bit timer counts down, state advances when it hits zero.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    par_d   = par_q;
    case (state_q)
      S_IDLE: begin
        if (txen) begin
          shift_d = din;
          idx_d   = '0;
          stop_d  = 1'b0;
          par_d   = (PARITY == 1) ? ~^din : ^din;
          timer_d = TLOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          timer_d = TLOAD;
          state_d = S_DATA;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_DATA: begin
        if (tick) begin
          timer_d = TLOAD;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = (PARITY != 0) ? S_PAR : S_STOP;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_PAR: begin
        if (tick) begin
          timer_d = TLOAD;
          state_d = S_STOP;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (STOPBITS == 2 && !stop_q) begin
            stop_d  = 1'b1;
            timer_d = TLOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b0;
    case (state_d)
      S_IDLE:  begin tx_d = 1'b1;       busy_d = 1'b0; end
      S_START: begin tx_d = 1'b0;       busy_d = 1'b1; end
      S_DATA:  begin tx_d = shift_d[0]; busy_d = 1'b1; end
      S_PAR:   begin tx_d = par_d;      busy_d = 1'b1; end
      S_STOP:  begin tx_d = 1'b1;       busy_d = 1'b1; end
      default: begin tx_d = 1'b1;       busy_d = 1'b0; end
    endcase
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover no parity, even, odd and
// two stop bits. Expected frames are hand-written as {stop, parity, data, start}.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       txen [4];
  logic [7:0] din  [4];
  logic       tx   [4];
  logic       busy [4];

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKDIV(4), .PARITY(0), .STOPBITS(1)) u0 (
    .clk(clk), .rst(rst), .txen(txen[0]), .din(din[0]), .busy(busy[0]), .tx(tx[0]));
  uart_tx #(.CLKDIV(4), .PARITY(2), .STOPBITS(1)) u1 (
    .clk(clk), .rst(rst), .txen(txen[1]), .din(din[1]), .busy(busy[1]), .tx(tx[1]));
  uart_tx #(.CLKDIV(4), .PARITY(1), .STOPBITS(1)) u2 (
    .clk(clk), .rst(rst), .txen(txen[2]), .din(din[2]), .busy(busy[2]), .tx(tx[2]));
  uart_tx #(.CLKDIV(3), .PARITY(0), .STOPBITS(2)) u3 (
    .clk(clk), .rst(rst), .txen(txen[3]), .din(din[3]), .busy(busy[3]), .tx(tx[3]));

  task automatic chk(input string tag, input logic o, input logic e);
    total++;
    assert (o === e) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0b expected=%0b", tag, o, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Entered just after the acceptance edge E. Checks tx/busy every cycle of
  // the frame, then idle at E+F. txen is held while c < hold_until, pulsed
  // with 0xFF at c == inj, otherwise dropped (din scrambled after acceptance).
  task automatic frame(input string name, input int sel, input int cd, input int nb,
                       input logic [11:0] bits, input int hold_until, input int inj);
    for (int c = 0; c < cd * nb; c++) begin
      chk($sformatf("%s tx c=%0d", name, c), tx[sel], bits[c / cd]);
      chk($sformatf("%s busy c=%0d", name, c), busy[sel], 1'b1);
      if (c < hold_until) txen[sel] = 1'b1;
      else if (c == inj) begin
        txen[sel] = 1'b1;
        din[sel]  = 8'hFF;
      end else begin
        txen[sel] = 1'b0;
        if (c == 0) din[sel] = 8'hC3;
      end
      cyc();
    end
    chk($sformatf("%s end busy", name), busy[sel], 1'b0);
    chk($sformatf("%s end tx", name), tx[sel], 1'b1);
  endtask

  task automatic start(input int sel, input logic [7:0] b);
    din[sel]  = b;
    txen[sel] = 1'b1;
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      txen[i] = 1'b0;
      din[i]  = 8'h00;
    end
    cyc();
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset tx u%0d", i), tx[i], 1'b1);
      chk($sformatf("reset busy u%0d", i), busy[i], 1'b0);
    end
    rst = 1'b0;
    cyc();

    // 'P' with no parity: 0,0,0,0,1,0,1,0,1 after start, 40 busy cycles
    start(0, 8'h50);
    frame("P", 0, 4, 10, {1'b1, 8'h50, 1'b0}, 0, -1);
    cyc();
    chk("P idle tx", tx[0], 1'b1);
    chk("P idle busy", busy[0], 1'b0);

    // dbgtouart handshake: back-to-back "P", "0", "\n"
    start(0, 8'h50);
    frame("hs0", 0, 4, 10, {1'b1, 8'h50, 1'b0}, 0, -1);
    start(0, 8'h30);
    frame("hs1", 0, 4, 10, {1'b1, 8'h30, 1'b0}, 0, -1);
    start(0, 8'h0A);
    frame("hs2", 0, 4, 10, {1'b1, 8'h0A, 1'b0}, 0, -1);

    // request with 0xFF during data bit 3 of a 0x00 frame is lost
    start(0, 8'h00);
    frame("ign", 0, 4, 10, {1'b1, 8'h00, 1'b0}, 0, 18);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("ign after busy k=%0d", k), busy[0], 1'b0);
      chk($sformatf("ign after tx k=%0d", k), tx[0], 1'b1);
    end

    // reset during data bit 3 (0x37 bit3 = 0), then a clean 0xA5 frame
    start(0, 8'h37);
    txen[0] = 1'b0;
    repeat (17) cyc();
    chk("rst pre tx", tx[0], 1'b0);
    chk("rst pre busy", busy[0], 1'b1);
    rst = 1'b1;
    cyc();
    chk("rst edge tx", tx[0], 1'b1);
    chk("rst edge busy", busy[0], 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("rst idle tx k=%0d", k), tx[0], 1'b1);
      chk($sformatf("rst idle busy k=%0d", k), busy[0], 1'b0);
    end
    start(0, 8'hA5);
    frame("A5", 0, 4, 10, {1'b1, 8'hA5, 1'b0}, 0, -1);

    // parity: 0x2C even -> 1, odd -> 0; 0x03 even -> 0, odd -> 1
    start(1, 8'h2C);
    frame("even2C", 1, 4, 11, {1'b1, 1'b1, 8'h2C, 1'b0}, 0, -1);
    start(2, 8'h2C);
    frame("odd2C", 2, 4, 11, {1'b1, 1'b0, 8'h2C, 1'b0}, 0, -1);
    start(1, 8'h03);
    frame("even03", 1, 4, 11, {1'b1, 1'b0, 8'h03, 1'b0}, 0, -1);
    start(2, 8'h03);
    frame("odd03", 2, 4, 11, {1'b1, 1'b1, 8'h03, 1'b0}, 0, -1);

    // two stop bits, CLKDIV 3: 33-cycle frames, txen held ~100 cycles
    // gives frames at cycles 0, 34, 68 and nothing after
    start(3, 8'h5A);
    frame("hold0", 3, 3, 11, {1'b1, 1'b1, 8'h5A, 1'b0}, 1000, -1);
    cyc();
    frame("hold1", 3, 3, 11, {1'b1, 1'b1, 8'h5A, 1'b0}, 1000, -1);
    cyc();
    frame("hold2", 3, 3, 11, {1'b1, 1'b1, 8'h5A, 1'b0}, 32, -1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("hold done busy k=%0d", k), busy[3], 1'b0);
      chk($sformatf("hold done tx k=%0d", k), tx[3], 1'b1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
